branch_rs: RTL



---
 rtl/branch_rs_if.sv | 45 ++++
 rtl/branch_rs.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/branch_rs_if.sv
// Bundle between dispatch/CDB producers, the branch reservation station and the branch unit.
//   master : dispatch request + CDB broadcast out, disp_ready + issue payload in
//   slave  : the reservation station (mirror of master)
interface branch_rs_if #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned OP_W  = 6
);
    // Dispatch
    logic             disp_valid;
    logic             disp_ready;
    logic [OP_W-1:0]  disp_op;
    logic [31:0]      disp_pc;
    logic [31:0]      disp_offset;
    logic [TAG_W-1:0] disp_tagx;
    logic [TAG_W-1:0] disp_tagy;
    logic [31:0]      disp_datax;
    logic [31:0]      disp_datay;
    // Common data bus
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    // Issue to branch unit
    logic             iss_busy;
    logic [OP_W-1:0]  iss_op;
    logic [31:0]      iss_pc;
    logic [31:0]      iss_offset;
    logic [TAG_W-1:0] iss_tagx;
    logic [TAG_W-1:0] iss_tagy;
    logic [31:0]      iss_datax;
    logic [31:0]      iss_datay;

    modport master (
        output disp_valid, disp_op, disp_pc, disp_offset, disp_tagx, disp_tagy,
               disp_datax, disp_datay, cdb_valid, cdb_tag, cdb_data,
        input  disp_ready, iss_busy, iss_op, iss_pc, iss_offset, iss_tagx, iss_tagy,
               iss_datax, iss_datay
    );

    modport slave (
        input  disp_valid, disp_op, disp_pc, disp_offset, disp_tagx, disp_tagy,
               disp_datax, disp_datay, cdb_valid, cdb_tag, cdb_data,
        output disp_ready, iss_busy, iss_op, iss_pc, iss_offset, iss_tagx, iss_tagy,
               iss_datax, iss_datay
    );
endinterface

// File: rtl/branch_rs.sv
// Branch reservation station: a compacting queue of DEPTH entries (entry 0 oldest) that
// captures operands from the CDB and issues the oldest operand-ready branch each cycle.
//   clk, rst_n : clock, async active-low reset
//   rdy_i      : global stall release; low freezes everything except flush
//   flush_i    : misprediction flush, empties the station
//   bus        : dispatch / CDB inputs, disp_ready and registered issue payload outputs
//   count_o    : number of occupied entries
module branch_rs #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       TAG_W    = 5,
    parameter int unsigned       OP_W     = 6,
    parameter logic [TAG_W-1:0]  UNLOCKED = '0,
    localparam int unsigned      CntW     = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy_i,
    input  logic            flush_i,
    branch_rs_if.slave      bus,
    output logic [CntW-1:0] count_o
);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [31:0]      pc;
        logic [31:0]      offset;
        logic [TAG_W-1:0] tagx;
        logic [31:0]      datax;
        logic [TAG_W-1:0] tagy;
        logic [31:0]      datay;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    // One spare slot so the shift of the top entry reads a defined value.
    entry_t          woken [DEPTH+1];
    entry_t          new_ent;
    entry_t          sel_ent;
    logic [CntW-1:0] count_q, count_d;
    logic [DEPTH-1:0] ready;
    logic            any_ready;
    logic            issue;
    logic            accept;
    logic            cdb_hit;
    int              sel_idx;
    int              tail_idx;

    logic            iss_busy_q;
    logic [OP_W-1:0] iss_op_q;
    logic [31:0]     iss_pc_q, iss_offset_q, iss_datax_q, iss_datay_q;

    assign bus.disp_ready = rdy_i && (count_q < CntW'(DEPTH));
    assign accept         = bus.disp_valid && bus.disp_ready && !flush_i;
    // The CDB producer stalls with rdy, so a broadcast only counts while rdy is high.
    assign cdb_hit        = rdy_i && bus.cdb_valid && (bus.cdb_tag != UNLOCKED);

    // Readiness looks only at registered state: a same-edge wakeup never issues.
    always_comb begin
        ready     = '0;
        any_ready = 1'b0;
        sel_idx   = 0;
        sel_ent   = ent_q[0];
        for (int i = 0; i < int'(DEPTH); i++) begin
            ready[i] = (CntW'(i) < count_q) && (ent_q[i].tagx == UNLOCKED) &&
                       (ent_q[i].tagy == UNLOCKED);
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (ready[i]) begin
                any_ready = 1'b1;
                sel_idx   = i;
                sel_ent   = ent_q[i];
            end
        end
    end

    assign issue = rdy_i && !flush_i && any_ready;

    // Incoming entry, with bypass from a same-cycle CDB broadcast.
    always_comb begin
        new_ent.op     = bus.disp_op;
        new_ent.pc     = bus.disp_pc;
        new_ent.offset = bus.disp_offset;
        new_ent.tagx   = bus.disp_tagx;
        new_ent.datax  = bus.disp_datax;
        new_ent.tagy   = bus.disp_tagy;
        new_ent.datay  = bus.disp_datay;
        if (cdb_hit && (bus.disp_tagx == bus.cdb_tag)) begin
            new_ent.tagx  = UNLOCKED;
            new_ent.datax = bus.cdb_data;
        end
        if (cdb_hit && (bus.disp_tagy == bus.cdb_tag)) begin
            new_ent.tagy  = UNLOCKED;
            new_ent.datay = bus.cdb_data;
        end
    end

    // Wakeup first, then compact over the issued slot, then append at the tail.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            woken[i] = ent_q[i];
            if (cdb_hit && (ent_q[i].tagx == bus.cdb_tag)) begin
                woken[i].tagx  = UNLOCKED;
                woken[i].datax = bus.cdb_data;
            end
            if (cdb_hit && (ent_q[i].tagy == bus.cdb_tag)) begin
                woken[i].tagy  = UNLOCKED;
                woken[i].datay = bus.cdb_data;
            end
        end
        woken[DEPTH] = '0;

        tail_idx = int'(count_q) - (issue ? 1 : 0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (issue && (i >= sel_idx)) begin
                ent_d[i] = woken[i+1];
            end else begin
                ent_d[i] = woken[i];
            end
            if (accept && (i == tail_idx)) begin
                ent_d[i] = new_ent;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (rdy_i) begin
            count_d = count_q + CntW'(accept) - CntW'(issue);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            count_q      <= '0;
            iss_busy_q   <= 1'b0;
            iss_op_q     <= '0;
            iss_pc_q     <= '0;
            iss_offset_q <= '0;
            iss_datax_q  <= '0;
            iss_datay_q  <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q    <= count_d;
            iss_busy_q <= issue;
            if (issue) begin
                iss_op_q     <= sel_ent.op;
                iss_pc_q     <= sel_ent.pc;
                iss_offset_q <= sel_ent.offset;
                iss_datax_q  <= sel_ent.datax;
                iss_datay_q  <= sel_ent.datay;
            end
        end
    end

    assign count_o        = count_q;
    assign bus.iss_busy   = iss_busy_q;
    assign bus.iss_op     = iss_op_q;
    assign bus.iss_pc     = iss_pc_q;
    assign bus.iss_offset = iss_offset_q;
    assign bus.iss_datax  = iss_datax_q;
    assign bus.iss_datay  = iss_datay_q;
    // Issued operands are always resolved.
    assign bus.iss_tagx   = UNLOCKED;
    assign bus.iss_tagy   = UNLOCKED;

endmodule
